// File: rtl/shift_rows_stream_if.sv
// Valid/ready stream bundle for the shift_rows_stream stage.
// The upstream side drives the column, the mode bit and in_valid.
// The downstream side drives out_ready.
interface shift_rows_stream_if;
  logic        decrypt;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;

  // Producer/consumer view: drives the input column, consumes the shifted column.
  modport master (
    output decrypt, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  // Stage view: accepts input columns, produces shifted columns.
  modport slave (
    input  decrypt, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/shift_rows_stream.sv
// Column-serial ShiftRows / InvShiftRows stage for Rijndael with NB = 4, 6 or 8 columns.
// The stage buffers one whole block in LOAD, then emits the row-shifted columns in DRAIN.
// Row offsets are 0,1,2,3, except for NB = 8, where they are 0,1,3,4.
module shift_rows_stream #(
  parameter int NB = 4
) (
  input  logic                clk,
  input  logic                rst,
  shift_rows_stream_if.slave  bus
);

  generate
    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
      $error("shift_rows_stream: NB must be 4, 6 or 8");
    end
  endgenerate

  localparam int              CW       = $clog2(NB);
  localparam logic [CW-1:0]   CNT_LAST = CW'(NB - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

  localparam logic [0:0] ST_LOAD  = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mode_q, mode_d;
  logic [31:0]   col_q [NB];
  logic [31:0]   shifted_col;
  logic          load_fire;
  logic          drain_fire;

  // Rotation amount for row r. NB = 8 uses the wider offsets for rows 2 and 3.
  function automatic int row_offset(input int r);
    case (r)
      0:       return 0;
      1:       return 1;
      2:       return (NB == 8) ? 3 : 2;
      default: return (NB == 8) ? 4 : 3;
    endcase
  endfunction

  // Source column for row r of output column col, wrapped modulo NB (not 2**CW).
  // For decrypt, the offset is subtracted by adding NB - offset.
  // The sum is always below 2*NB, so one conditional subtract is enough for the wrap.
  function automatic logic [CW-1:0] src_col(input logic [CW-1:0] col, input int r,
                                            input logic dec);
    int s;
    s = int'(col) + (dec ? (NB - row_offset(r)) : row_offset(r));
    if (s >= NB) s = s - NB;
    return CW'(s);
  endfunction

  assign load_fire  = (state_q == ST_LOAD)  && bus.in_valid;
  assign drain_fire = (state_q == ST_DRAIN) && bus.out_ready;

  // Assemble the shifted column for the current output index from the buffered block.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    shifted_col = '0;
    for (int r = 0; r < 4; r++) begin
      shifted_col[31-8*r -: 8] = col_q[src_col(cnt_q, r, mode_q)][31-8*r -: 8];
    end
  end

  assign bus.in_ready  = (state_q == ST_LOAD);
  assign bus.out_valid = (state_q == ST_DRAIN);
  assign bus.out_data  = (state_q == ST_DRAIN) ? shifted_col : 32'h0;
  assign bus.out_last  = (state_q == ST_DRAIN) && (cnt_q == CNT_LAST);

  // Next-state logic: LOAD fills the buffer and DRAIN walks through the shifted columns.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    if (load_fire) begin
      if (cnt_q == '0) mode_d = bus.decrypt;
      if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        state_d = ST_DRAIN;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
    if (drain_fire) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        state_d = ST_LOAD;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst) begin
      state_q <= ST_LOAD;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  // Column buffer: write at the load index, and clear it on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: this buffer is cleared on reset on purpose, so a discarded block can never leak into a later drain.
      for (int i = 0; i < NB; i++) col_q[i] <= '0;
    end else if (load_fire) begin
      col_q[cnt_q] <= bus.in_data;
    end
  end

endmodule

// File: tb/tb_shift_rows_stream.sv
// Directed bench for shift_rows_stream with NB = 4, 6 and 8 instances.
// The instance under test is picked by sel.
module tb_shift_rows_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, decrypt, out_ready;
  logic [31:0] in_data;
  int          sel;
  int          checks = 0;
  int          errors = 0;

  logic        obs_in_ready, obs_out_valid, obs_out_last;
  logic [31:0] obs_out_data;

  always #5 clk = ~clk;

  shift_rows_stream_if if4 ();
  shift_rows_stream_if if6 ();
  shift_rows_stream_if if8 ();

  assign if4.in_valid  = in_valid  && (sel == 4);
  assign if6.in_valid  = in_valid  && (sel == 6);
  assign if8.in_valid  = in_valid  && (sel == 8);
  assign if4.out_ready = out_ready && (sel == 4);
  assign if6.out_ready = out_ready && (sel == 6);
  assign if8.out_ready = out_ready && (sel == 8);
  assign if4.in_data = in_data;
  assign if6.in_data = in_data;
  assign if8.in_data = in_data;
  assign if4.decrypt = decrypt;
  assign if6.decrypt = decrypt;
  assign if8.decrypt = decrypt;

  shift_rows_stream #(.NB(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
  shift_rows_stream #(.NB(6)) dut6 (.clk(clk), .rst(rst), .bus(if6.slave));
  shift_rows_stream #(.NB(8)) dut8 (.clk(clk), .rst(rst), .bus(if8.slave));

  always_comb begin
    obs_in_ready  = if4.in_ready;
    obs_out_valid = if4.out_valid;
    obs_out_last  = if4.out_last;
    obs_out_data  = if4.out_data;
    if (sel == 6) begin
      obs_in_ready  = if6.in_ready;
      obs_out_valid = if6.out_valid;
      obs_out_last  = if6.out_last;
      obs_out_data  = if6.out_data;
    end else if (sel == 8) begin
      obs_in_ready  = if8.in_ready;
      obs_out_valid = if8.out_valid;
      obs_out_last  = if8.out_last;
      obs_out_data  = if8.out_data;
    end
  end

  // Plain inputs: column c holds bytes 4c..4c+3.
  logic [31:0] seq_cols [8] = '{32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F,
                                32'h10111213, 32'h14151617, 32'h18191A1B, 32'h1C1D1E1F};
  logic [31:0] exp4_enc [8] = '{32'h00050A0F, 32'h04090E03, 32'h080D0207, 32'h0C01060B,
                                32'h0, 32'h0, 32'h0, 32'h0};
  logic [31:0] exp4_dec [8] = '{32'h000D0A07, 32'h04010E0B, 32'h0805020F, 32'h0C090603,
                                32'h0, 32'h0, 32'h0, 32'h0};
  logic [31:0] exp6_enc [8] = '{32'h00050A0F, 32'h04090E13, 32'h080D1217, 32'h0C111603,
                                32'h10150207, 32'h1401060B, 32'h0, 32'h0};
  logic [31:0] exp8_enc [8] = '{32'h00050E13, 32'h04091217, 32'h080D161B, 32'h0C111A1F,
                                32'h10151E03, 32'h14190207, 32'h181D060B, 32'h1C010A0F};

  // Drive n columns, one per cycle. The mode bit is dec_first on column 0 and dec_rest afterwards.
  task automatic load_block(input logic [31:0] cols [8], input int n,
                            input logic dec_first, input logic dec_rest);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = cols[i];
      decrypt  = (i == 0) ? dec_first : dec_rest;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_data  = 32'h0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    sel = 4; in_valid = 1'b0; out_ready = 1'b0; decrypt = 1'b0; in_data = 32'h0;
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (obs_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", obs_in_ready); end
    checks++; if (obs_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", obs_out_valid); end
    checks++; if (obs_out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h exp 0", obs_out_data); end
    checks++; if (obs_out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b exp 0", obs_out_last); end
  endtask

  // NB=4 encrypt. in_valid is held high with junk during DRAIN, and it must be ignored.
  task automatic test_nb4_encrypt();
    sel = 4; out_ready = 1'b1;
    load_block(seq_cols, 4, 1'b0, 1'b0);
    in_valid = 1'b1; in_data = 32'hDEADBEEF;
    checks++; if (obs_out_valid !== 1'b1) begin errors++; $display("FAIL enc4_latency out_valid got %b exp 1", obs_out_valid); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (obs_out_data !== exp4_enc[i]) begin errors++; $display("FAIL enc4_data[%0d] got %h exp %h", i, obs_out_data, exp4_enc[i]); end
      checks++; if (obs_out_last !== (i == 3)) begin errors++; $display("FAIL enc4_last[%0d] got %b exp %b", i, obs_out_last, i == 3); end
      checks++; if (obs_in_ready !== 1'b0) begin errors++; $display("FAIL enc4_in_ready[%0d] got %b exp 0", i, obs_in_ready); end
      if (i == 3) in_valid = 1'b0;
      @(posedge clk); #1;
    end
    checks++; if (obs_in_ready !== 1'b1) begin errors++; $display("FAIL enc4_in_ready_after got %b exp 1", obs_in_ready); end
    checks++; if (obs_out_valid !== 1'b0) begin errors++; $display("FAIL enc4_out_valid_after got %b exp 0", obs_out_valid); end
  endtask

  task automatic test_nb4_decrypt();
    sel = 4; out_ready = 1'b1;
    load_block(seq_cols, 4, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checks++; if (obs_out_valid !== 1'b1 || obs_out_data !== exp4_dec[i]) begin
        errors++; $display("FAIL dec4_data[%0d] got %h (valid %b) exp %h", i, obs_out_data, obs_out_valid, exp4_dec[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_nb8_roundtrip();
    sel = 8; out_ready = 1'b1;
    load_block(seq_cols, 8, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      checks++; if (obs_out_valid !== 1'b1 || obs_out_data !== exp8_enc[i] || obs_out_last !== (i == 7)) begin
        errors++; $display("FAIL enc8[%0d] got %h last %b exp %h", i, obs_out_data, obs_out_last, exp8_enc[i]);
      end
      @(posedge clk); #1;
    end
    load_block(exp8_enc, 8, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      checks++; if (obs_out_valid !== 1'b1 || obs_out_data !== seq_cols[i]) begin
        errors++; $display("FAIL dec8[%0d] got %h exp %h", i, obs_out_data, seq_cols[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_nb6_roundtrip();
    sel = 6; out_ready = 1'b1;
    load_block(seq_cols, 6, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      checks++; if (obs_out_valid !== 1'b1 || obs_out_data !== exp6_enc[i] || obs_out_last !== (i == 5)) begin
        errors++; $display("FAIL enc6[%0d] got %h last %b exp %h", i, obs_out_data, obs_out_last, exp6_enc[i]);
      end
      @(posedge clk); #1;
    end
    load_block(exp6_enc, 6, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      checks++; if (obs_out_valid !== 1'b1 || obs_out_data !== seq_cols[i]) begin
        errors++; $display("FAIL dec6[%0d] got %h exp %h", i, obs_out_data, seq_cols[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  // Stalled output must hold. decrypt changes after column 0 must not affect the block.
  task automatic test_backpressure();
    int idx;
    int k;
    sel = 4; out_ready = 1'b0;
    load_block(seq_cols, 4, 1'b0, 1'b1);
    idx = 0; k = 0;
    while (idx < 4 && k < 40) begin
      out_ready = ((k % 4) == 0) || ((k % 4) == 3);
      checks++; if (obs_out_valid !== 1'b1 || obs_out_data !== exp4_enc[idx] || obs_out_last !== (idx == 3)) begin
        errors++; $display("FAIL bp_col[%0d] cyc %0d got %h valid %b last %b exp %h", idx, k,
                           obs_out_data, obs_out_valid, obs_out_last, exp4_enc[idx]);
      end
      @(posedge clk); #1;
      if (out_ready) idx++;
      k++;
    end
    out_ready = 1'b0;
    checks++; if (idx != 4) begin errors++; $display("FAIL bp_timeout got %0d columns exp 4", idx); end
    checks++; if (obs_in_ready !== 1'b1 || obs_out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_return_load in_ready %b out_valid %b exp 1 0", obs_in_ready, obs_out_valid);
    end
  endtask

  task automatic test_reset_mid_block();
    sel = 4; out_ready = 1'b0;
    load_block(seq_cols, 2, 1'b0, 1'b0);
    pulse_reset();
    checks++; if (obs_in_ready !== 1'b1 || obs_out_valid !== 1'b0 || obs_out_data !== 32'h0) begin
      errors++; $display("FAIL rst_load in_ready %b out_valid %b out_data %h exp 1 0 0", obs_in_ready, obs_out_valid, obs_out_data);
    end
    load_block(seq_cols, 4, 1'b0, 1'b0);
    out_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    out_ready = 1'b0;
    pulse_reset();
    checks++; if (obs_in_ready !== 1'b1 || obs_out_valid !== 1'b0 || obs_out_data !== 32'h0) begin
      errors++; $display("FAIL rst_drain in_ready %b out_valid %b out_data %h exp 1 0 0", obs_in_ready, obs_out_valid, obs_out_data);
    end
    out_ready = 1'b1;
    load_block(seq_cols, 4, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checks++; if (obs_out_valid !== 1'b1 || obs_out_data !== exp4_dec[i] || obs_out_last !== (i == 3)) begin
        errors++; $display("FAIL rst_fresh[%0d] got %h last %b exp %h", i, obs_out_data, obs_out_last, exp4_dec[i]);
      end
      @(posedge clk); #1;
    end
    checks++; if (obs_out_valid !== 1'b0) begin errors++; $display("FAIL rst_no_stale out_valid got %b exp 0", obs_out_valid); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; decrypt = 1'b0; in_data = 32'h0; sel = 4;
    test_reset();
    test_nb4_encrypt();
    test_nb4_decrypt();
    test_nb8_roundtrip();
    test_nb6_roundtrip();
    test_backpressure();
    test_reset_mid_block();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
